// File: rtl/huffman_encoder.sv
// huffman_encoder: three-symbol Huffman encoder; HUFF_STATE_OUT_EN exposes the FSM state on io_out[11:9].
module huffman_encoder #(
  parameter int CHAR_COUNT = 3,
  parameter int FREQ_W = 3,
  parameter int CODE_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);
  localparam logic [2:0] IDLE = 3'd0, MERGE1 = 3'd1, MERGE2 = 3'd2, ENCODE = 3'd3, OUT = 3'd4;
  logic [2:0] st, ocnt, st_out;
  logic [1:0] cnt, rem, r, s0, s1, osym;
  logic [7:0] chr [CHAR_COUNT];
  logic [FREQ_W-1:0] frq [CHAR_COUNT];
  logic [CODE_W-1:0] code [CHAR_COUNT];
  logic [CODE_W-1:0] mask [CHAR_COUNT];
  logic [4:0] nf3;
  logic b3, s1_0, s2_0, s2_1;
`ifdef HUFF_STATE_OUT_EN
  always_comb st_out = st;
`else
  always_comb st_out = 3'b0;
`endif
  // x_y: node x counts as smaller than node y (ties favour the higher index)
  always_comb begin
    s1_0 = frq[1] <= frq[0];
    s2_0 = frq[2] <= frq[0];
    s2_1 = frq[2] <= frq[1];
    r = (s1_0 && s2_0) ? 2'd0 : (!s1_0 && s2_1) ? 2'd1 : 2'd2;
    s0 = r == 2'd0 ? (s2_1 ? 2'd2 : 2'd1) : r == 2'd1 ? (s2_0 ? 2'd2 : 2'd0) : (s1_0 ? 2'd1 : 2'd0);
    s1 = 2'd3 - r - s0;
    osym = ocnt[2:1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      ocnt <= '0;
      rem <= '0;
      nf3 <= '0;
      b3 <= 1'b0;
      io_out <= '0;
      for (int i = 0; i < CHAR_COUNT; i++) begin
        chr[i] <= '0;
        frq[i] <= '0;
        code[i] <= '0;
        mask[i] <= '0;
      end
    end else begin
      io_out <= {st_out, 9'b0};
      case (st)
        IDLE: if (io_in[11]) begin
          chr[cnt] <= io_in[7:0];
          frq[cnt] <= io_in[10:8];
          cnt <= cnt == 2'(CHAR_COUNT - 1) ? 2'd0 : cnt + 2'd1;
          if (cnt == 2'(CHAR_COUNT - 1)) st <= MERGE1;
        end
        MERGE1: begin
          code[s0] <= 3'b000;
          code[s1] <= 3'b001;
          mask[s0] <= 3'b011;
          mask[s1] <= 3'b011;
          rem <= r;
          nf3 <= 5'(frq[s0]) + 5'(frq[s1]);
          st <= MERGE2;
        end
        MERGE2: begin
          b3 <= nf3 > 5'(frq[rem]);
          st <= ENCODE;
        end
        ENCODE: begin
          // prefix the node-3 subtree with its root edge; the lone leaf takes the other edge
          for (int i = 0; i < CHAR_COUNT; i++) begin
            if (2'(i) == rem) begin
              code[i] <= {2'b00, ~b3};
              mask[i] <= 3'b001;
            end else code[i] <= {1'b0, b3, code[i][0]};
          end
          ocnt <= '0;
          st <= OUT;
        end
        OUT: begin
          io_out <= {st_out, 1'b1, ocnt[0] ? {2'b00, mask[osym], code[osym]} : chr[osym]};
          ocnt <= ocnt + 3'd1;
          if (ocnt == 3'd5) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_huffman_encoder.sv
// tb_huffman_encoder: directed and random vectors checked against a generic Huffman tree model.
module tb_huffman_encoder;
  logic clk = 1'b0;
  logic reset;
  logic [11:0] io_in, io_out;
  int checks = 0, errors = 0;
  logic [7:0] chr_v [3];
  logic [2:0] frq_v [3];
  logic [8:0] exp_w [6];
`ifdef HUFF_STATE_OUT_EN
  logic [11:0] cmp_mask = 12'h1FF;
`else
  logic [11:0] cmp_mask = 12'hFFF;
`endif
  huffman_encoder dut (.clk(clk), .reset(reset), .io_in(io_in), .io_out(io_out));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert ((obs & cmp_mask) === (exp & cmp_mask)) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs & cmp_mask, exp & cmp_mask);
    end
  endtask
  // repeated two-smallest merge over a node list, then leaf-to-root walk
  task automatic model;
    int f [5];
    int par [5];
    int eb [5];
    bit used [5];
    for (int i = 0; i < 5; i++) begin
      f[i] = i < 3 ? int'(frq_v[i]) : 0;
      par[i] = -1;
      eb[i] = 0;
      used[i] = 0;
    end
    for (int n = 3; n < 5; n++) begin
      for (int e = 0; e < 2; e++) begin
        int best = -1;
        for (int j = 0; j < n; j++)
          if (!used[j] && (best < 0 || f[j] < f[best] || (f[j] == f[best] && j > best))) best = j;
        used[best] = 1;
        par[best] = n;
        eb[best] = e;
        f[n] += f[best];
      end
    end
    for (int i = 0; i < 3; i++) begin
      int v = 0, len = 0, node = i;
      while (node != 4) begin
        v |= eb[node] << len;
        len++;
        node = par[node];
      end
      exp_w[2*i] = {1'b1, chr_v[i]};
      exp_w[2*i+1] = {1'b1, 2'b00, 3'((1 << len) - 1), 3'(v)};
    end
  endtask
  task automatic send_vec(input int gap, input bit stray, input int nw);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        io_in = '0;
        repeat (gap) step;
      end
      io_in = {1'b1, frq_v[k], chr_v[k]};
      step;
      if (k == 0) chk("idle_before_vec", io_out, 12'h000);
    end
    io_in = '0;
    repeat (3) step;
    chk("encode_quiet", io_out, 12'h000);
    for (int w = 0; w < nw; w++) begin
      if (stray && w == 2) io_in = {1'b1, 3'($urandom), 8'($urandom)};
      step;
      io_in = '0;
      chk($sformatf("word%0d", w), io_out, {3'b000, exp_w[w]});
    end
  endtask
  task automatic set_anm;
    chr_v = '{8'h61, 8'h6E, 8'h6D};
    frq_v = '{3'd4, 3'd2, 3'd2};
    exp_w = '{9'h161, 9'h109, 9'h16E, 9'h119, 9'h16D, 9'h118};
  endtask
  task automatic set_rand;
    for (int i = 0; i < 3; i++) begin
      chr_v[i] = 8'($urandom);
      frq_v[i] = 3'($urandom);
    end
    model;
  endtask
  initial begin
    reset = 1'b1;
    io_in = '0;
    repeat (2) step;
    chk("reset_out", io_out, 12'h000);
    reset = 1'b0;
    set_anm;
    send_vec(0, 0, 6);
    chr_v = '{8'h78, 8'h79, 8'h7A};
    frq_v = '{3'd1, 3'd2, 3'd4};
    exp_w = '{9'h178, 9'h118, 9'h179, 9'h119, 9'h17A, 9'h109};
    send_vec(0, 0, 6);
    chr_v = '{8'h61, 8'h62, 8'h63};
    frq_v = '{3'd2, 3'd2, 3'd2};
    exp_w = '{9'h161, 9'h108, 9'h162, 9'h11B, 9'h163, 9'h11A};
    send_vec(0, 0, 6);
    for (int v = 0; v < 5; v++) begin
      set_rand;
      send_vec(0, 0, 6);
    end
    set_anm;
    send_vec(0, 0, 3);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("reset_mid_out", io_out, 12'h000);
    io_in = {1'b1, 3'd7, 8'h55};
    step;
    io_in = {1'b1, 3'd1, 8'hAA};
    step;
    io_in = '0;
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("reset_partial", io_out, 12'h000);
    set_anm;
    send_vec(0, 0, 6);
    set_anm;
    send_vec(2, 1, 6);
    chr_v = '{8'h78, 8'h79, 8'h7A};
    frq_v = '{3'd1, 3'd2, 3'd4};
    exp_w = '{9'h178, 9'h118, 9'h179, 9'h119, 9'h17A, 9'h109};
    send_vec(0, 0, 6);
    for (int v = 0; v < 12; v++) begin
      set_rand;
      send_vec(int'($urandom_range(0, 3)), 1'($urandom), 6);
    end
    step;
    chk("final_idle", io_out, 12'h000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
